// File: rtl/cla_pkg.sv
// cla_pkg: shared nibble width and FSM encoding for the serial CLA word adder
package cla_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/cla_serial_word_adder_if.sv
// cla_serial_word_adder_if: operand/result valid-ready bus of the serial adder
interface cla_serial_word_adder_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  modport master(output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave(input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/carry_look_ahead_adder.sv
// carry_look_ahead_adder: 4-bit slice with fully expanded look-ahead carries
module carry_look_ahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/cla_serial_word_adder.sv
// cla_serial_word_adder: WIDTH-bit adder streaming one nibble per clock through a single CLA slice
module cla_serial_word_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  cla_serial_word_adder_if.slave bus
);
  localparam int NNIB = WIDTH / NIB_W;
  localparam int IW = NNIB > 1 ? $clog2(NNIB) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic cout_q, cout_d, ovf_q, ovf_d;
  logic [NIB_W-1:0] s;
  logic c, last;
  carry_look_ahead_adder u_slice (
    .a(a_q[NIB_W*idx_q +: NIB_W]),
    .b(b_q[NIB_W*idx_q +: NIB_W]),
    .cin(carry_q),
    .sum(s),
    .cout(c)
  );
  assign last = idx_q == IW'(NNIB - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d = bus.a;
        b_d = bus.b;
        carry_d = bus.cin;
        idx_d = '0;
        in_ready_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[NIB_W*idx_q +: NIB_W] = s;
        carry_d = c;
        idx_d = idx_q + 1'b1;
        if (last) begin
          state_d = DONE;
          out_valid_d = 1'b1;
          cout_d = c;
          // the top nibble is still in flight, so take the sign from the slice output
          ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[NIB_W-1] != a_q[WIDTH-1]);
        end
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_cla_serial_word_adder.sv
// tb_cla_serial_word_adder: directed checks of 16-, 8- and 4-bit builds of the serial CLA adder
module tb_cla_serial_word_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n = 0;
  int fails = 0;
  int acc8 = 0;
  int res8 = 0;
  always #5 clk = ~clk;
  cla_serial_word_adder_if #(.WIDTH(16)) b16 ();
  cla_serial_word_adder_if #(.WIDTH(8)) b8 ();
  cla_serial_word_adder_if #(.WIDTH(4)) b4 ();
  cla_serial_word_adder #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  cla_serial_word_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  cla_serial_word_adder #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic [15:0] es, input logic ec, input logic eo, input string tag);
    int k;
    @(negedge clk);
    b16.a = a; b16.b = b; b16.cin = ci; b16.in_valid = 1'b1;
    chk({tag, " in_ready"}, 32'(b16.in_ready), 1);
    @(posedge clk); #1 b16.in_valid = 1'b0;
    k = 0;
    while (!b16.out_valid && k < 20) begin @(posedge clk); #1 k++; end
    chk({tag, " latency"}, k, 4);
    chk({tag, " sum"}, 32'(b16.sum), 32'(es));
    chk({tag, " cout"}, 32'(b16.cout), 32'(ec));
    chk({tag, " ovf"}, 32'(b16.ovf), 32'(eo));
    if (b16.out_ready) begin
      @(posedge clk); #1;
      chk({tag, " drained"}, 32'({b16.out_valid, b16.in_ready}), 32'b01);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] e;
    int k, st;
    e = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    st = $urandom_range(0, 3);
    @(negedge clk);
    b8.a = a; b8.b = b; b8.cin = ci; b8.in_valid = 1'b1; b8.out_ready = (st == 0);
    @(posedge clk); #1 b8.in_valid = 1'b0;
    acc8++;
    k = 0;
    while (!b8.out_valid && k < 20) begin @(posedge clk); #1 k++; end
    if (b8.out_valid) res8++;
    chk("w8 latency", k, 2);
    chk("w8 cout_sum", 32'({b8.cout, b8.sum}), 32'(e));
    chk("w8 ovf", 32'(b8.ovf), 32'((a[7] == b[7]) && (e[7] != a[7])));
    if (st > 0) begin
      repeat (st) @(posedge clk);
      @(negedge clk);
      chk("w8 held", 32'({b8.out_valid, b8.cout, b8.sum}), 32'({1'b1, e}));
      b8.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("w8 drained", 32'(b8.out_valid), 0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                     input logic [3:0] es, input logic ec, input logic eo);
    int k;
    @(negedge clk);
    b4.a = a; b4.b = b; b4.cin = ci; b4.in_valid = 1'b1;
    @(posedge clk); #1 b4.in_valid = 1'b0;
    k = 0;
    while (!b4.out_valid && k < 20) begin @(posedge clk); #1 k++; end
    chk("w4 latency", k, 1);
    chk("w4 sum", 32'(b4.sum), 32'(es));
    chk("w4 cout", 32'(b4.cout), 32'(ec));
    chk("w4 ovf", 32'(b4.ovf), 32'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] corner [6];
    corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};
    b16.in_valid = 0; b16.a = 0; b16.b = 0; b16.cin = 0; b16.out_ready = 0;
    b8.in_valid = 0; b8.a = 0; b8.b = 0; b8.cin = 0; b8.out_ready = 1;
    b4.in_valid = 0; b4.a = 0; b4.b = 0; b4.cin = 0; b4.out_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset in_ready", 32'(b16.in_ready), 1);
    chk("reset out_valid", 32'(b16.out_valid), 0);
    chk("reset sum/cout/ovf", 32'({b16.sum, b16.cout, b16.ovf}), 0);
    @(negedge clk) rst_n = 1'b1;

    op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "t1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b16.a = 16'($urandom); b16.b = 16'($urandom); b16.cin = ~b16.cin; b16.in_valid = i[0];
      @(posedge clk); #1;
      chk("bp out_valid", 32'(b16.out_valid), 1);
      chk("bp in_ready", 32'(b16.in_ready), 0);
      chk("bp result", 32'({b16.cout, b16.ovf, b16.sum}), 32'({2'b00, 16'h5556}));
    end
    @(negedge clk); b16.in_valid = 1'b0; b16.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release", 32'({b16.out_valid, b16.in_ready}), 32'b01);

    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "t2a");
    op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "t2b");
    op16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "negwrap");

    @(negedge clk);
    b16.a = 16'hAAAA; b16.b = 16'h5555; b16.cin = 1'b1; b16.in_valid = 1'b1;
    @(posedge clk); #1 b16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(b16.in_ready), 1);
    chk("midrst outputs", 32'({b16.out_valid, b16.cout, b16.ovf, b16.sum}), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst held", 32'(b16.out_valid), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("midrst no pulse", 32'(b16.out_valid), 0);
    end
    op16(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "postrst");

    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int c = 0; c < 2; c++)
          op8(corner[i], corner[j], c[0]);
    chk("w8 txn count", res8, acc8);

    op4(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
    op4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
